// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES block packer slice.
// The block packer's optional byte swap is selected by AES_BLOCK_PACKER_BSWAP_EN.
package aes_pkg;

    localparam int AES_WORD_W       = 16;
    localparam int AES_WORDS        = 8;
    localparam int AES_BLOCK_W      = AES_WORD_W * AES_WORDS;
    localparam int AES_READ_LAT     = 2;
    localparam int AES_CNT_W        = 16;
    localparam int AES_TOTAL_BLOCKS = 65535;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FIFO,
        ST_ISSUE,
        ST_LATENCY,
        ST_CAPTURE,
        ST_PRESENT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/aes_word_shifter.sv
// Block assembly register: places successive FIFO words into lanes 0..WORDS-1.
// With AES_BLOCK_PACKER_BSWAP_EN defined each word is byte-swapped on load.
import aes_pkg::*;

module aes_word_shifter #(
    parameter int DATA_W = AES_WORD_W,
    parameter int WORDS  = AES_WORDS
) (
    input  logic                    iCLK,
    input  logic                    iRST_n,
    input  logic                    load_en,
    input  logic                    clear,
    input  logic [DATA_W-1:0]       word,
    output logic [DATA_W*WORDS-1:0] block,
    output logic                    last_word
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [IDX_W-1:0]  idx_reg;
    logic [DATA_W-1:0] word_fmt;

`ifdef AES_BLOCK_PACKER_BSWAP_EN
    // Byte order reversed within the word for big-endian sources.
    generate
        for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_bswap
            assign word_fmt[8*gi +: 8] = word[DATA_W-8-8*gi +: 8];
        end
    endgenerate
`else
    assign word_fmt = word;
`endif

    assign last_word = (idx_reg == IDX_W'(WORDS - 1));

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            idx_reg <= '0;
        end else if (clear) begin
            idx_reg <= '0;
        end else if (load_en) begin
            idx_reg <= last_word ? '0 : idx_reg + IDX_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_lane
            logic [DATA_W-1:0] lane_reg;

            always_ff @(posedge iCLK or negedge iRST_n) begin
                if (!iRST_n) begin
                    lane_reg <= '0;
                end else if (clear) begin
                    lane_reg <= '0;
                end else if (load_en && (idx_reg == IDX_W'(gi))) begin
                    lane_reg <= word_fmt;
                end
            end

            assign block[DATA_W*gi +: DATA_W] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/aes_block_packer.sv
// Pulls WORDS FIFO words per block, presents 128-bit blocks on valid/ready, stops after TOTAL_BLOCKS.
// Optional byte swap of each word: define AES_BLOCK_PACKER_BSWAP_EN.
import aes_pkg::*;

module aes_block_packer #(
    parameter int DATA_W       = AES_WORD_W,
    parameter int WORDS        = AES_WORDS,
    parameter int READ_LAT     = AES_READ_LAT,
    parameter int CNT_W        = AES_CNT_W,
    parameter int TOTAL_BLOCKS = AES_TOTAL_BLOCKS
) (
    input  logic                    iCLK,
    input  logic                    iRST_n,
    input  logic                    iSTART,
    input  logic                    iCLR,
    input  logic [CNT_W-1:0]        iFIFO_USED,
    input  logic                    iFIFO_BUSY,
    output logic                    oREAD,
    input  logic [DATA_W-1:0]       iREADDATA,
    output logic [DATA_W*WORDS-1:0] oBLOCK,
    output logic                    oBLOCK_VALID,
    input  logic                    iBLOCK_READY,
    output logic                    oBUSY,
    output logic                    oDONE,
    output logic [CNT_W-1:0]        oBLOCK_CNT
);

    localparam int LAT_W = 3;

    state_t           state_reg, state_next;
    logic [LAT_W-1:0] lat_reg, lat_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             done_reg, done_next;
    logic             shift_load, shift_clear, shift_last;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_reg <= ST_IDLE;
            lat_reg   <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            lat_reg   <= lat_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        lat_next    = lat_reg;
        cnt_next    = cnt_reg;
        done_next   = done_reg;
        shift_load  = 1'b0;
        shift_clear = 1'b0;

        if (iCLR) begin
            // Abort drops any partial block but keeps the run statistics.
            state_next  = ST_IDLE;
            shift_clear = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (iSTART) begin
                        state_next  = ST_WAIT_FIFO;
                        cnt_next    = '0;
                        done_next   = 1'b0;
                        shift_clear = 1'b1;
                    end
                end
                ST_WAIT_FIFO: begin
                    // One level check covers the whole burst of WORDS reads.
                    if ((iFIFO_USED >= CNT_W'(WORDS)) && !iFIFO_BUSY) begin
                        state_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    lat_next   = LAT_W'(1);
                    state_next = (READ_LAT == 1) ? ST_CAPTURE : ST_LATENCY;
                end
                ST_LATENCY: begin
                    if (lat_reg == LAT_W'(READ_LAT)) begin
                        state_next = ST_CAPTURE;
                    end else begin
                        lat_next = lat_reg + LAT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    shift_load = 1'b1;
                    state_next = shift_last ? ST_PRESENT : ST_ISSUE;
                end
                ST_PRESENT: begin
                    if (iBLOCK_READY) begin
                        cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);
                        if (cnt_next == CNT_W'(TOTAL_BLOCKS)) begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_WAIT_FIFO;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    aes_word_shifter #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS)
    ) u_shifter (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .load_en   (shift_load),
        .clear     (shift_clear),
        .word      (iREADDATA),
        .block     (oBLOCK),
        .last_word (shift_last)
    );

    assign oREAD        = (state_reg == ST_ISSUE);
    assign oBLOCK_VALID = (state_reg == ST_PRESENT);
    assign oBUSY        = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign oDONE        = done_reg;
    assign oBLOCK_CNT   = cnt_reg;

endmodule

// File: doc/aes_block_packer.md
Name: aes_block_packer

Overview:
Upstream feeder for the AES encrypt/decrypt stage. Pulls 16-bit words from the SDRAM read-side FIFO. Assembles each group of 8 words into a 128-bit plaintext/ciphertext block and presents it with a valid/ready handshake. Counts blocks, stops after a programmed total, and raises a sticky done flag.

Parameters:
DATA_W, 16, FIFO word width
WORDS, 8, words per block (block width = DATA_W*WORDS = 128)
READ_LAT, 2, cycles from oREAD pulse to iREADDATA valid (1..7)
CNT_W, 16, width of block counter and FIFO level
TOTAL_BLOCKS, 65535, blocks per run (1 MB at 16 B/block minus one)

Ports:
iCLK  in  1  system clock
iRST_n  in  1  asynchronous active-low reset
iSTART  in  1  start pulse; sampled only in IDLE
iCLR  in  1  synchronous abort; returns to IDLE, counter kept
iFIFO_USED  in  CNT_W  read-FIFO fill level
iFIFO_BUSY  in  1  SDRAM controller refilling FIFO; no reads while high
oREAD  out  1  one-cycle FIFO read strobe
iREADDATA  in  DATA_W  FIFO data, valid READ_LAT cycles after oREAD
oBLOCK  out  DATA_W*WORDS  assembled block
oBLOCK_VALID  out  1  oBLOCK valid
iBLOCK_READY  in  1  AES stage accepts block
oBUSY  out  1  high in any state except IDLE/DONE
oDONE  out  1  sticky: TOTAL_BLOCKS delivered
oBLOCK_CNT  out  CNT_W  blocks accepted since start

Behaviour:
- Reset (async, iRST_n=0): state IDLE. All outputs 0: oREAD, oBLOCK, oBLOCK_VALID, oBUSY, oDONE, oBLOCK_CNT. Word index and latency counter also 0.
- States: IDLE, WAIT_FIFO, ISSUE, LATENCY, CAPTURE, PRESENT, DONE.
- IDLE: when iSTART=1 -> WAIT_FIFO. On this transition oBLOCK_CNT and oDONE clear and oBLOCK clears to 0.
- WAIT_FIFO: when iFIFO_USED >= WORDS and iFIFO_BUSY=0 -> ISSUE with word index 0. Otherwise stay.
- Reads within a block are not rechecked against the level; the whole burst of WORDS reads is guaranteed by the entry check.
- ISSUE: oREAD=1 for exactly this cycle -> LATENCY with latency counter = 1.
- LATENCY: counter increments until it equals READ_LAT -> CAPTURE. If READ_LAT=1, go directly to CAPTURE after ISSUE.
- CAPTURE: iREADDATA written to oBLOCK[DATA_W*idx +: DATA_W]; word 0 lands in the LSBs. If idx==WORDS-1 -> PRESENT with oBLOCK_VALID=1; else idx++ and -> ISSUE.
- Per-word cost is READ_LAT+2 cycles. With defaults, the first oREAD to oBLOCK_VALID is 8*4 = 32 cycles.
- PRESENT: oBLOCK and oBLOCK_VALID stay stable until iBLOCK_READY=1. On the accept cycle, oBLOCK_VALID drops next cycle and oBLOCK_CNT++. Then:
  - if the new count == TOTAL_BLOCKS -> DONE, oDONE=1;
  - else -> WAIT_FIFO.
  - iBLOCK_READY asserted before valid has no effect.
- DONE: holds, oDONE=1, oBUSY=0. iSTART restarts a new run (same as from IDLE).
- iCLR=1 in any state -> IDLE next cycle. oREAD and oBLOCK_VALID drop and the partially assembled block is discarded. oBLOCK_CNT and oDONE are held. iCLR has priority over iSTART and iBLOCK_READY.
- iSTART while busy: ignored.
- oBLOCK_CNT saturates at all-ones and never wraps.
- oREAD never asserts in two consecutive cycles and never while iFIFO_BUSY was high at the WAIT_FIFO decision.

Optional Feature:
Macro AES_BLOCK_PACKER_BSWAP_EN.
- Defined: each captured word is byte-swapped ({d[7:0],d[15:8]}) before it is placed in oBLOCK, for big-endian SD-card streams.
- Undefined: words are stored unchanged.
- Timing and state flow are identical either way.

Decomposition:
- Shared package aes_pkg: state encoding enum, AES_BLOCK_W=128, AES_WORD_W=16, AES_WORDS=8, default TOTAL_BLOCKS constant.
- One natural sub-module, aes_word_shifter: holds the 128-bit assembly register, the word index and the optional byte swap. Its interface is load-enable, word-in, clear and block-out.
- The FSM and counters stay in the top module.

Test Plan:
- Reset mid-CAPTURE (iRST_n low 1 cycle) -> all outputs 0 immediately; oREAD silent afterwards until a new iSTART.
- iFIFO_USED=8, iFIFO_BUSY=0, iSTART, FIFO returns 0x0001..0x0008 with READ_LAT=2 -> exactly 8 oREAD pulses 4 cycles apart; oBLOCK=0x0008_0007_0006_0005_0004_0003_0002_0001; valid 32 cycles after the first oREAD.
- Hold iBLOCK_READY=0 for 20 cycles, then pulse 1 -> oBLOCK stable, no oREAD during the wait; oBLOCK_CNT 0->1 and WAIT_FIFO re-entered.
- iFIFO_USED=7, or iFIFO_USED=8 with iFIFO_BUSY=1 -> no oREAD; raise to 8 with busy=0 -> burst starts the next cycle.
- TOTAL_BLOCKS=3, always ready -> oDONE rises on the third accept, oBLOCK_CNT=3, no further oREAD; iSTART restarts with count 0.
- iCLR after 5 captured words -> IDLE, no valid; with BSWAP_EN, word 0x1234 appears as 0x3412.
